// File: rtl/mb_serial_frame_rx.sv
// Serial frame receiver for the CRC-3 lab link: start bit, DATA_W data bits and 3 CRC bits, all MSB first.
// Optional stop-bit checking is compiled in with `define MB_RX_STOP_BIT_EN.
module mb_serial_frame_rx #(
    parameter int          DATA_W   = 8,
    parameter logic [2:0]  CRC_POLY = 3'b011,
    parameter logic [2:0]  CRC_INIT = 3'b000
) (
    input  logic              CLK,
    input  logic              CLEAR_bar,
    input  logic              Enable,
    input  logic              Serial_In,
    input  logic              Ack,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Valid,
    output logic              CRC_Error,
    output logic              Overrun,
    output logic              Busy,
    output logic              Frame_Error
);

    localparam int CNT_W = $clog2(DATA_W + 1);

`ifdef MB_RX_STOP_BIT_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [2:0]          crc_q, crc_d, crc_step;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                crc_err_q, crc_err_d;
    logic                ovr_q, ovr_d;
    logic                ferr_q, ferr_d;
    logic                done;
    logic                stop_bad;

    // Serial CRC: feedback is the outgoing MSB xor the incoming bit.
    always_comb begin
        crc_step = {crc_q[1:0], 1'b0};
        if (crc_q[2] ^ Serial_In) crc_step = crc_step ^ CRC_POLY;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        crc_d    = crc_q;
        done     = 1'b0;
        stop_bad = 1'b0;
        if (Enable) begin
            case (state_q)
                S_IDLE: begin
                    if (!Serial_In) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        crc_d   = CRC_INIT;
                    end
                end
                S_DATA: begin
                    shift_d = {shift_q[DATA_W-2:0], Serial_In};
                    crc_d   = crc_step;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_CRC: begin
                    crc_d = crc_step;
                    if (cnt_q == CNT_W'(2)) begin
`ifdef MB_RX_STOP_BIT_EN
                        state_d = S_STOP;
`else
                        state_d = S_IDLE;
                        done    = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef MB_RX_STOP_BIT_EN
                S_STOP: begin
                    state_d  = S_IDLE;
                    done     = 1'b1;
                    stop_bad = !Serial_In;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Completion wins over Ack; Ack on the completing edge only suppresses overrun.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        crc_err_d = crc_err_q;
        ovr_d     = ovr_q;
        ferr_d    = ferr_q;
        if (done) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            crc_err_d = |crc_d;
            ferr_d    = stop_bad;
            if (Ack)          ovr_d = 1'b0;
            else if (valid_q) ovr_d = 1'b1;
        end else if (Ack && valid_q) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLEAR_bar) begin
        if (!CLEAR_bar) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            crc_q     <= CRC_INIT;
            data_q    <= '0;
            valid_q   <= 1'b0;
            crc_err_q <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            crc_q     <= crc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            crc_err_q <= crc_err_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign Data_Out  = data_q;
    assign Valid     = valid_q;
    assign CRC_Error = crc_err_q;
    assign Overrun   = ovr_q;
    assign Busy      = (state_q != S_IDLE);
`ifdef MB_RX_STOP_BIT_EN
    assign Frame_Error = ferr_q;
`else
    assign Frame_Error = 1'b0;
`endif

endmodule
